fetch_stage: RTL and testbench

//  Instruction-fetch (IF) stage of the 5-stage ARM pipeline, directly upstream of the instruction memory.

---
 rtl/fetch_stage.sv | 103 ++++++++++
 tb/tb_fetch_stage.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage of the 5-stage ARM pipeline. Owns the program
//   counter, presents it as the byte address to a combinational-read
//   instruction memory, and registers the returned word together with PC+4
//   into the IF/ID pipeline register. Handles hazard freeze and taken-branch
//   redirect with IF/ID flush.
//
// Ports
//   clk           in   rising-edge clock
//   rst           in   asynchronous reset, active-low
//   freeze        in   hazard stall: hold PC and IF/ID register
//   branch_taken  in   redirect PC to branch_addr and flush IF/ID
//   branch_addr   in   branch target byte address (low two bits ignored)
//   imem_addr     out  byte address to instruction memory (equals pc)
//   imem_data     in   instruction word for imem_addr
//   pc            out  current PC register
//   if_pc_out     out  IF/ID: PC+4 of the latched instruction
//   if_instr_out  out  IF/ID: latched instruction word
//   if_valid_out  out  IF/ID: 1 = real instruction, 0 = bubble
//   fetch_count   out  number of valid instructions latched since reset
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter int                   INST_LEN = 32,
  parameter logic [INST_LEN-1:0]  RESET_PC = 32'h0000_0000,
  parameter logic [INST_LEN-1:0]  NOP      = 32'hE000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                freeze,
  input  logic                branch_taken,
  input  logic [INST_LEN-1:0] branch_addr,
  output logic [INST_LEN-1:0] imem_addr,
  input  logic [INST_LEN-1:0] imem_data,
  output logic [INST_LEN-1:0] pc,
  output logic [INST_LEN-1:0] if_pc_out,
  output logic [INST_LEN-1:0] if_instr_out,
  output logic                if_valid_out,
  output logic [31:0]         fetch_count
);

  logic [INST_LEN-1:0] pc_next;
  logic [INST_LEN-1:0] pc_d;
  logic [INST_LEN-1:0] if_pc_d;
  logic [INST_LEN-1:0] if_instr_d;
  logic                if_valid_d;
  logic [31:0]         fetch_count_d;

  // The memory address is the PC register itself; freeze and branch only
  // affect what gets loaded at the next edge, never the current address.
  assign imem_addr = pc;

  // Sequential successor address; wraps silently at the top of the space.
  assign pc_next = pc + {{(INST_LEN-3){1'b0}}, 3'd4};

  // Next-state selection: branch_taken overrides freeze, freeze overrides advance.
  always_comb begin
    pc_d          = pc;
    if_pc_d       = if_pc_out;
    if_instr_d    = if_instr_out;
    if_valid_d    = if_valid_out;
    fetch_count_d = fetch_count;
    if (branch_taken) begin
      // Target is forced word-aligned; the IF/ID slot becomes a bubble and
      // imem_data is not consulted, so garbage on it cannot leak through.
      pc_d          = {branch_addr[INST_LEN-1:2], 2'b00};
      if_pc_d       = {INST_LEN{1'b0}};
      if_instr_d    = NOP;
      if_valid_d    = 1'b0;
      fetch_count_d = fetch_count;
    end else if (freeze) begin
      pc_d          = pc;
      if_pc_d       = if_pc_out;
      if_instr_d    = if_instr_out;
      if_valid_d    = if_valid_out;
      fetch_count_d = fetch_count;
    end else begin
      pc_d          = pc_next;
      if_pc_d       = pc_next;
      if_instr_d    = imem_data;
      if_valid_d    = 1'b1;
      fetch_count_d = fetch_count + 32'd1;
    end
  end

  // PC and IF/ID pipeline register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc           <= RESET_PC;
      if_pc_out    <= {INST_LEN{1'b0}};
      if_instr_out <= NOP;
      if_valid_out <= 1'b0;
      fetch_count  <= 32'd0;
    end else begin
      pc           <= pc_d;
      if_pc_out    <= if_pc_d;
      if_instr_out <= if_instr_d;
      if_valid_out <= if_valid_d;
      fetch_count  <= fetch_count_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//   Directed scoreboard bench for fetch_stage. A driver applies one input
//   vector per negedge and queues the hand-computed IF state expected after
//   the following posedge; a monitor pops and compares shortly after every
//   posedge. The instruction memory returns 0xE1A00000 | (addr >> 2), and a
//   junk word on freeze/branch cycles to show it never reaches IF/ID.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

  typedef struct {
    int          id;
    logic [31:0] pc;
    logic [31:0] ifpc;
    logic [31:0] instr;
    logic        valid;
    logic [31:0] cnt;
  } exp_t;

  localparam logic [31:0] NOP  = 32'hE000_0000;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = 32'd0;
  logic        junk = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc;
  logic [31:0] if_pc_out;
  logic [31:0] if_instr_out;
  logic        if_valid_out;
  logic [31:0] fetch_count;

  int   n_vec = 0;
  int   n_err = 0;
  int   next_id = 0;
  exp_t exp_q[$];

  fetch_stage dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .pc           (pc),
    .if_pc_out    (if_pc_out),
    .if_instr_out (if_instr_out),
    .if_valid_out (if_valid_out),
    .fetch_count  (fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'hE1A0_0000 | (a >> 2);
  endfunction

  assign imem_data = junk ? JUNK : word_at(imem_addr);

  task automatic compare(input exp_t e);
    n_vec++;
    if (pc !== e.pc || imem_addr !== e.pc || if_pc_out !== e.ifpc ||
        if_instr_out !== e.instr || if_valid_out !== e.valid || fetch_count !== e.cnt) begin
      n_err++;
      $display("FAIL vec%0d: got pc=%h addr=%h ifpc=%h instr=%h valid=%b cnt=%0d, expected pc=%h ifpc=%h instr=%h valid=%b cnt=%0d",
               e.id, pc, imem_addr, if_pc_out, if_instr_out, if_valid_out, fetch_count,
               e.pc, e.ifpc, e.instr, e.valid, e.cnt);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] epc, input logic [31:0] eifpc,
                              input logic [31:0] einstr, input logic ev,
                              input logic [31:0] ecnt);
    exp_t e;
    e.id = next_id;
    next_id++;
    e.pc = epc;
    e.ifpc = eifpc;
    e.instr = einstr;
    e.valid = ev;
    e.cnt = ecnt;
    return e;
  endfunction

  // Apply one vector at a negedge and queue the state expected after the next posedge.
  task automatic step(input logic fz, input logic br, input logic [31:0] ba,
                      input logic [31:0] epc, input logic [31:0] eifpc,
                      input logic [31:0] einstr, input logic ev, input logic [31:0] ecnt);
    @(negedge clk);
    rst          = 1'b1;
    freeze       = fz;
    branch_taken = br;
    branch_addr  = ba;
    junk         = fz | br;
    exp_q.push_back(mk(epc, eifpc, einstr, ev, ecnt));
  endtask

  // Monitor: compare the queued expectation just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compare(e);
      end
    end
  end

  initial begin
    // Reset held low across an edge.
    #12;
    compare(mk(32'h0, 32'h0, NOP, 1'b0, 32'd0));

    // Sequential fetch from 0.
    step(1'b0, 1'b0, 32'h0, 32'h4, 32'h4, 32'hE1A0_0000, 1'b1, 32'd1);
    step(1'b0, 1'b0, 32'h0, 32'h8, 32'h8, 32'hE1A0_0001, 1'b1, 32'd2);
    // Freeze two edges at pc=8 with junk on the memory bus.
    step(1'b1, 1'b0, 32'h0, 32'h8, 32'h8, 32'hE1A0_0001, 1'b1, 32'd2);
    step(1'b1, 1'b0, 32'h0, 32'h8, 32'h8, 32'hE1A0_0001, 1'b1, 32'd2);
    // Release resumes at 8.
    step(1'b0, 1'b0, 32'h0, 32'hC, 32'hC, 32'hE1A0_0002, 1'b1, 32'd3);
    // Branch wins over freeze; misaligned target 0x93 -> 0x90.
    step(1'b1, 1'b1, 32'h93, 32'h90, 32'h0, NOP, 1'b0, 32'd3);
    step(1'b0, 1'b0, 32'h0, 32'h94, 32'h94, 32'hE1A0_0024, 1'b1, 32'd4);
    // Back-to-back branches: last one wins.
    step(1'b0, 1'b1, 32'h200, 32'h200, 32'h0, NOP, 1'b0, 32'd4);
    step(1'b0, 1'b1, 32'h301, 32'h300, 32'h0, NOP, 1'b0, 32'd4);
    step(1'b0, 1'b0, 32'h0, 32'h304, 32'h304, 32'hE1A0_00C0, 1'b1, 32'd5);
    // Wrap at the top of the address space.
    step(1'b0, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0, NOP, 1'b0, 32'd5);
    step(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b1, 32'd6);
    step(1'b0, 1'b0, 32'h0, 32'h4, 32'h4, 32'hE1A0_0000, 1'b1, 32'd7);
    // Branch to the address being fetched: still one bubble.
    step(1'b0, 1'b1, 32'h4, 32'h4, 32'h0, NOP, 1'b0, 32'd7);
    step(1'b0, 1'b0, 32'h0, 32'h8, 32'h8, 32'hE1A0_0001, 1'b1, 32'd8);
    // Reach pc=0x40, fetch_count=16.
    step(1'b0, 1'b1, 32'h20, 32'h20, 32'h0, NOP, 1'b0, 32'd8);
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 1'b0, 32'h0, 32'h20 + 32'(4*k), 32'h20 + 32'(4*k),
           32'hE1A0_0000 | 32'(7 + k), 1'b1, 32'd8 + 32'(k));
    end
    // Park with freeze so the state stays at pc=0x40.
    step(1'b1, 1'b0, 32'h0, 32'h40, 32'h40, 32'hE1A0_000F, 1'b1, 32'd16);
    // Asynchronous reset between edges: outputs clear with no clock edge.
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    compare(mk(32'h0, 32'h0, NOP, 1'b0, 32'd0));
    // Release and fetch again from 0.
    step(1'b0, 1'b0, 32'h0, 32'h4, 32'h4, 32'hE1A0_0000, 1'b1, 32'd1);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
